axi4_slave_wdata_ctrl: RTL and testbench
========================================

Name: axi4_slave_wdata_ctrl

Overview:
Parametrised AXI4 slave write-data controller. Queues accepted write-address commands (ID, AWLEN) in a small command FIFO, then receives W beats per command. Each beat is forwarded through a one-stage register to the slave memory write port. The block checks WLAST against the expected beat count, masks strobes on malformed bursts, and issues an in-order per-burst response request (ID plus error flag) to the B-channel logic.

Parameters:
DATA_WIDTH, 32, W data width in bits (multiple of 8)
ID_WIDTH, 4, AXI ID width
LEN_WIDTH, 8, AWLEN width (beats minus 1, AXI4 encoding)
CMD_DEPTH, 4, command FIFO depth (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
awvalid  in  1  AW command valid (address decode done upstream)
awready  out  1  command FIFO can accept
awid  in  ID_WIDTH  burst ID
awlen  in  LEN_WIDTH  beats-1
wvalid  in  1  W beat valid
wready  out  1  W beat accept
wdata  in  DATA_WIDTH  write data
wstrb  in  DATA_WIDTH/8  byte strobes
wlast  in  1  master's last-beat marker
mem_wvalid  out  1  memory write beat valid
mem_wready  in  1  memory accepts beat
mem_wdata  out  DATA_WIDTH  beat data
mem_wstrb  out  DATA_WIDTH/8  beat strobes (possibly masked)
mem_beat  out  LEN_WIDTH  beat index within burst, 0-based
mem_id  out  ID_WIDTH  burst ID of beat
resp_valid  out  1  burst-complete response request
resp_ready  in  1  B-channel logic takes response
resp_id  out  ID_WIDTH  ID of completed burst
resp_err  out  1  1 = WLAST protocol error in burst (SLVERR)
busy  out  1  state!=IDLE or FIFO non-empty or mem_wvalid

Behaviour:
- Reset: clk edge with rst=1 empties FIFO, sets FSM to IDLE, clears beat counter and error flag. awready, wready, mem_wvalid, resp_valid, resp_err and busy read 0. All data outputs read 0. awready is forced 0 while rst=1.
- Command FIFO: awready = !full. Push {awid,awlen} on awvalid&&awready. Pop only in IDLE when non-empty. Simultaneous push+pop keeps the count. A push into an empty FIFO becomes visible the next cycle.
- FSM IDLE: if FIFO non-empty, pop into cur_id/cur_len, clear beat_cnt and err, go to DATA.
- Latency: AW handshake at cycle N, earliest wready=1 at N+2.
- FSM DATA: wready = (!mem_wvalid || mem_wready), i.e. combinational from the output-register state.
- Beat accepted on wvalid&&wready. The output register loads wdata, masked strobe, beat_cnt and cur_id, with mem_wvalid=1 next cycle. mem_wvalid is held until mem_wready; a back-to-back handshake reloads in the same cycle.
- Expected last beat is beat_cnt==cur_len.
- A beat is bad if wlast != (beat_cnt==cur_len). A bad beat sets sticky err.
- mem_wstrb = wstrb when err is clear and the beat is good. Otherwise it is 0, so the bad beat and all later beats in the burst are forwarded with zero strobes.
- The burst always ends on the expected-last beat, regardless of wlast. A beat with wlast=1 that is not last does not end the burst. On acceptance of the expected-last beat: DATA->RESP.
- beat_cnt increments per accepted beat. Width is LEN_WIDTH, and wrap is unreachable because the burst ends at cur_len. awlen=0 gives a single beat.
- FSM RESP: wready=0. resp_valid = !mem_wvalid, so the response is asserted only after the last beat drains. resp_id=cur_id, resp_err=err. On resp_valid&&resp_ready go to IDLE.
- resp_valid/resp_id/resp_err are stable while resp_valid=1 and resp_ready=0.
- AW acceptance continues in all states while not full. Responses come out in AW order.
- Reset mid-burst: partial burst and queued commands are discarded. No response is issued for them.

Test Plan:
1. awid=5, awlen=3; 4 beats wdata 0xA0..0xA3, wstrb=0xF, wlast on beat 3; mem_wready=1 -> 4 mem beats, mem_beat 0..3, mem_id=5, mem_wstrb=0xF; resp_id=5, resp_err=0; first wready 2 cycles after AW handshake.
2. awlen=3, wlast=1 on beat 1 -> beats 0 strobe 0xF, beats 1..3 mem_wstrb=0; burst still takes 4 beats; resp_err=1. Next burst (awlen=0, correct wlast) gives resp_err=0.
3. awlen=2, wlast=0 on beat 2 -> beat 2 mem_wstrb=0, burst ends after beat 2, resp_err=1. A following wvalid beat is not accepted until the next command.
4. resp_ready=0; 5 back-to-back AW (ids 1..5, awlen=0) -> awready low after 4 FIFO entries plus one popped. Release resp_ready -> responses ids 1..5 in order; none lost.
5. awlen=7, mem_wready toggling 1,0,0,1 -> exactly 8 mem beats, no duplicates. wready=0 whenever mem_wvalid&&!mem_wready. resp_valid rises only the cycle after the final mem handshake.
6. rst=1 mid-burst (beat 2 of awlen=5, 2 commands queued) -> next cycle all outputs 0, busy=0; after rst=0 awready=1 and no resp_valid is issued for discarded bursts.

Source files
------------

// File: rtl/axi4_slave_wdata_ctrl.sv
// ---------------------------------------------------------------------------
// axi4_slave_wdata_ctrl
//
// AXI4 slave write-data controller. Accepted AW commands (ID, AWLEN) wait in
// a small command FIFO. The FSM pops one command at a time and accepts
// AWLEN+1 W beats for it. Each beat passes through a one-entry output
// register towards the memory write port. WLAST is checked against the
// expected beat count. The first beat that disagrees sets a sticky error,
// and from that beat on every beat of the burst is forwarded with zero
// strobes. The burst always ends on the expected-last beat. After the last
// beat has drained to memory, an in-order response request (ID + error) is
// raised for the B-channel logic.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   awvalid/awready AW command handshake; awid, awlen = burst ID, beats-1
//   wvalid/wready   W beat handshake; wdata, wstrb, wlast
//   mem_wvalid/     memory write beat handshake; mem_wdata, mem_wstrb
//   mem_wready      (masked), mem_beat (0-based index), mem_id
//   resp_valid/     burst response request; resp_id, resp_err (SLVERR)
//   resp_ready
//   busy            FSM active, commands queued, or a beat still held
// ---------------------------------------------------------------------------
module axi4_slave_wdata_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int LEN_WIDTH  = 8,
  parameter int CMD_DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [LEN_WIDTH-1:0]    awlen,
  input  logic                    wvalid,
  output logic                    wready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  output logic                    mem_wvalid,
  input  logic                    mem_wready,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  output logic [LEN_WIDTH-1:0]    mem_beat,
  output logic [ID_WIDTH-1:0]     mem_id,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [ID_WIDTH-1:0]     resp_id,
  output logic                    resp_err,
  output logic                    busy
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int PTR_W  = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [ID_WIDTH-1:0]  id;
    logic [LEN_WIDTH-1:0] len;
  } cmd_t;

  // A beat is malformed when the master's WLAST disagrees with our own
  // notion of which beat is last.
  function automatic logic beat_bad(input logic last_in, input logic last_exp);
    return last_in != last_exp;
  endfunction

  // Strobes are suppressed once the burst is known to be malformed.
  function automatic logic [STRB_W-1:0] mask_strb(input logic [STRB_W-1:0] s,
                                                  input logic              drop);
    return drop ? '0 : s;
  endfunction

  state_t               state, state_nxt;

  cmd_t                 cmd_mem [CMD_DEPTH];
  cmd_t                 cmd_head;
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     fifo_cnt;
  logic                 fifo_full, fifo_empty;
  logic                 push, pop;

  logic [ID_WIDTH-1:0]  cur_id;
  logic [LEN_WIDTH-1:0] cur_len;
  logic [LEN_WIDTH-1:0] beat_cnt;
  logic                 err;

  logic                 beat_acc;
  logic                 beat_is_last;
  logic                 bad_p0;
  logic [STRB_W-1:0]    strb_p0;

  logic                 vld_p1;
  logic [DATA_WIDTH-1:0] data_p1;
  logic [STRB_W-1:0]    strb_p1;
  logic [LEN_WIDTH-1:0] beat_p1;
  logic [ID_WIDTH-1:0]  id_p1;

  // -------------------------------------------------------------------------
  // Command FIFO
  // -------------------------------------------------------------------------
  assign fifo_full  = (fifo_cnt == CNT_W'(CMD_DEPTH));
  assign fifo_empty = (fifo_cnt == '0);
  assign awready    = !rst && !fifo_full;
  assign push       = awvalid && awready;
  assign cmd_head   = cmd_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) cmd_mem[wr_ptr] <= '{id: awid, len: awlen};
  end

  // -------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (!fifo_empty)              state_nxt = S_DATA;
      S_DATA:  if (beat_acc && beat_is_last) state_nxt = S_RESP;
      S_RESP:  if (resp_valid && resp_ready) state_nxt = S_IDLE;
      default:                               state_nxt = S_IDLE;
    endcase
  end

  // wready only looks at the output register, so a stalled memory port
  // back-pressures W directly while a draining register refills in the
  // same cycle.
  always_comb begin
    pop        = 1'b0;
    wready     = 1'b0;
    resp_valid = 1'b0;
    unique case (state)
      S_IDLE:  pop        = !fifo_empty;
      S_DATA:  wready     = !vld_p1 || mem_wready;
      S_RESP:  resp_valid = !vld_p1;
      default: ;
    endcase
  end

  assign busy     = (state != S_IDLE) || !fifo_empty || vld_p1;
  assign resp_id  = cur_id;
  assign resp_err = err;

  // -------------------------------------------------------------------------
  // Stage p0: beat checking in front of the output register
  // -------------------------------------------------------------------------
  assign beat_acc     = wvalid && wready;
  assign beat_is_last = (beat_cnt == cur_len);
  assign bad_p0       = beat_bad(wlast, beat_is_last);
  assign strb_p0      = mask_strb(wstrb, err || bad_p0);

  // Burst context. beat_cnt steps past cur_len on the final beat, but the
  // FSM has left DATA by then so that value is never used.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_id   <= '0;
      cur_len  <= '0;
      beat_cnt <= '0;
      err      <= 1'b0;
    end else if (pop) begin
      cur_id   <= cmd_head.id;
      cur_len  <= cmd_head.len;
      beat_cnt <= '0;
      err      <= 1'b0;
    end else if (beat_acc) begin
      beat_cnt <= beat_cnt + LEN_WIDTH'(1);
      err      <= err || bad_p0;
    end
  end

  // -------------------------------------------------------------------------
  // Stage p1: memory output register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      strb_p1 <= '0;
      beat_p1 <= '0;
      id_p1   <= '0;
    end else if (beat_acc) begin
      vld_p1  <= 1'b1;
      data_p1 <= wdata;
      strb_p1 <= strb_p0;
      beat_p1 <= beat_cnt;
      id_p1   <= cur_id;
    end else if (mem_wready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign mem_wvalid = vld_p1;
  assign mem_wdata  = data_p1;
  assign mem_wstrb  = strb_p1;
  assign mem_beat   = beat_p1;
  assign mem_id     = id_p1;

endmodule

// File: tb/tb_axi4_slave_wdata_ctrl.sv
module tb_axi4_slave_wdata_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [3:0]  awid = '0;
  logic [7:0]  awlen = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        mem_wvalid;
  logic        mem_wready = 1'b1;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [7:0]  mem_beat;
  logic [3:0]  mem_id;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [3:0]  resp_id;
  logic        resp_err;
  logic        busy;

  always #5 clk = ~clk;

  axi4_slave_wdata_ctrl #(
    .DATA_WIDTH(32), .ID_WIDTH(4), .LEN_WIDTH(8), .CMD_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awlen(awlen),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .mem_wvalid(mem_wvalid), .mem_wready(mem_wready), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_beat(mem_beat), .mem_id(mem_id),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_err(resp_err), .busy(busy)
  );

  typedef struct { logic [3:0] id; logic [7:0] len; } aw_t;
  typedef struct { logic [31:0] data; logic [3:0] strb; logic last; } w_t;
  typedef struct packed { logic [31:0] data; logic [3:0] strb; logic [7:0] beat; logic [3:0] id; } mb_t;
  typedef struct packed { logic [3:0] id; logic err; } resp_t;
  typedef struct { logic [3:0] id; logic [7:0] len; int last_at; logic exp_err; int exp_good; int exp_total; } vec_t;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input string msg);
    n_vec++;
    n_err++;
    $display("FAIL %s: %s (cycle %0d)", name, msg, cyc);
  endtask

  // Stimulus queues and driver controls
  aw_t aw_q[$];
  w_t  w_q[$];
  int  aw_rate = 100, w_rate = 100, mem_mode = 0, resp_mode = 0, pc = 0;
  logic [3:0] pat = 4'b1001;

  // Handshake flags observed at the negedge preceding the next active edge
  logic aw_fire = 0, w_fire = 0, mem_fire = 0, resp_fire = 0;

  // Reference model: stream-level view of AW commands, accepted W beats,
  // expected memory beats and expected responses.
  aw_t   m_cmd[$];
  mb_t   m_mem[$];
  resp_t m_resp[$];
  int    m_k = 0;
  logic  m_err = 0;

  int   n_resp = 0, n_wfire = 0;
  int   burst_tot = 0, burst_good = 0, last_tot = 0, last_good = 0;
  logic [3:0] last_resp_id = '0;
  logic last_resp_err = 0;
  int   aw_fire_cyc = 0, wready_rise_cyc = 0, last_mem_cyc = 0, resp_rise_cyc = 0;
  logic prev_mem_stall = 0, prev_resp_stall = 0, prev_wready = 0, prev_resp_valid = 0;
  mb_t  prev_mb;
  logic [3:0] prev_rid;
  logic prev_rerr;

  always @(negedge clk) begin
    aw_t   c;
    mb_t   mb;
    resp_t rr;
    logic  exp_last;
    cyc++;
    if (rst) begin
      aw_fire = 0; w_fire = 0; mem_fire = 0; resp_fire = 0;
      m_cmd.delete(); m_mem.delete(); m_resp.delete();
      m_k = 0; m_err = 0; burst_tot = 0; burst_good = 0;
      prev_mem_stall = 0; prev_resp_stall = 0; prev_wready = 0; prev_resp_valid = 0;
    end else begin
      aw_fire   = awvalid && awready;
      w_fire    = wvalid && wready;
      mem_fire  = mem_wvalid && mem_wready;
      resp_fire = resp_valid && resp_ready;

      if (mem_wvalid && !mem_wready) chk("wready_while_stalled", 64'(wready), 64'd0);
      if (resp_valid) chk("resp_before_drain", 64'(mem_wvalid), 64'd0);
      if (prev_mem_stall)
        chk("mem_hold", 64'({mem_wvalid, mem_wdata, mem_wstrb, mem_beat, mem_id}), 64'({1'b1, prev_mb}));
      if (prev_resp_stall)
        chk("resp_hold", 64'({resp_valid, resp_id, resp_err}), 64'({1'b1, prev_rid, prev_rerr}));
      if (wready && !prev_wready) wready_rise_cyc = cyc;
      if (resp_valid && !prev_resp_valid) resp_rise_cyc = cyc;

      if (w_fire) begin
        n_wfire++;
        if (m_cmd.size() == 0) begin
          fail_now("w_accept", "beat accepted with no outstanding command");
        end else begin
          c = m_cmd[0];
          exp_last = (m_k == int'(c.len));
          if (wlast != exp_last) m_err = 1;
          mb = '{data: wdata, strb: (m_err ? 4'h0 : wstrb), beat: 8'(m_k), id: c.id};
          m_mem.push_back(mb);
          m_k++;
          if (exp_last) begin
            m_resp.push_back('{id: c.id, err: m_err});
            c = m_cmd.pop_front();
            m_k = 0;
            m_err = 0;
          end
        end
      end
      if (aw_fire) begin
        m_cmd.push_back('{id: awid, len: awlen});
        aw_fire_cyc = cyc;
      end
      if (mem_fire) begin
        burst_tot++;
        if (mem_wstrb != 4'h0) burst_good++;
        last_mem_cyc = cyc;
        if (m_mem.size() == 0) fail_now("mem_beat", "unexpected memory beat");
        else begin
          mb = m_mem.pop_front();
          chk("mem_beat", 64'({mem_wdata, mem_wstrb, mem_beat, mem_id}), 64'(mb));
        end
      end
      if (resp_fire) begin
        n_resp++;
        last_resp_id = resp_id;
        last_resp_err = resp_err;
        last_tot = burst_tot;
        last_good = burst_good;
        burst_tot = 0;
        burst_good = 0;
        if (m_resp.size() == 0) fail_now("resp", "unexpected response");
        else begin
          rr = m_resp.pop_front();
          chk("resp", 64'({resp_id, resp_err}), 64'(rr));
        end
      end

      prev_mem_stall  = mem_wvalid && !mem_wready;
      prev_mb         = '{data: mem_wdata, strb: mem_wstrb, beat: mem_beat, id: mem_id};
      prev_resp_stall = resp_valid && !resp_ready;
      prev_rid        = resp_id;
      prev_rerr       = resp_err;
      prev_wready     = wready;
      prev_resp_valid = resp_valid;
    end
  end

  // Drivers: inputs change 1 time unit after the active edge
  always @(posedge clk) begin
    aw_t tmp_aw;
    w_t  tmp_w;
    #1;
    if (aw_fire && aw_q.size() > 0) tmp_aw = aw_q.pop_front();
    if (aw_q.size() == 0) awvalid = 1'b0;
    else begin
      if (!awvalid || aw_fire) awvalid = (int'($urandom_range(99)) < aw_rate);
      awid  = aw_q[0].id;
      awlen = aw_q[0].len;
    end
    if (w_fire && w_q.size() > 0) tmp_w = w_q.pop_front();
    if (w_q.size() == 0) wvalid = 1'b0;
    else begin
      if (!wvalid || w_fire) wvalid = (int'($urandom_range(99)) < w_rate);
      wdata = w_q[0].data;
      wstrb = w_q[0].strb;
      wlast = w_q[0].last;
    end
    case (mem_mode)
      0: mem_wready = 1'b1;
      1: begin mem_wready = pat[pc % 4]; pc++; end
      default: mem_wready = ($urandom_range(99) < 70);
    endcase
    case (resp_mode)
      0: resp_ready = 1'b1;
      1: resp_ready = 1'b0;
      default: resp_ready = ($urandom_range(1) == 1);
    endcase
  end

  task automatic send_burst(input logic [3:0] id, input logic [7:0] len, input int last_at,
                            input logic [31:0] base);
    aw_q.push_back('{id: id, len: len});
    for (int b = 0; b <= int'(len); b++)
      w_q.push_back('{data: base + 32'(b), strb: 4'hF, last: (b == last_at)});
  endtask

  task automatic wait_resp(input int target, input int budget, input string name);
    int i = 0;
    while (n_resp < target && i < budget) begin
      @(posedge clk);
      i++;
    end
    chk(name, 64'(n_resp >= target), 64'd1);
  endtask

  task automatic chk_zero_outputs(input string p);
    chk({p, "_awready"},    64'(awready), 64'd0);
    chk({p, "_wready"},     64'(wready), 64'd0);
    chk({p, "_mem_wvalid"}, 64'(mem_wvalid), 64'd0);
    chk({p, "_resp_valid"}, 64'(resp_valid), 64'd0);
    chk({p, "_resp_err"},   64'(resp_err), 64'd0);
    chk({p, "_busy"},       64'(busy), 64'd0);
    chk({p, "_mem_data"},   64'({mem_wdata, mem_wstrb, mem_beat, mem_id}), 64'd0);
    chk({p, "_resp_id"},    64'(resp_id), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    int   n0, nw0, i;
    logic [7:0] len;
    tbl[0] = '{4'd5,  8'd3,   3,   1'b0, 4,   4};
    tbl[1] = '{4'd6,  8'd3,   1,   1'b1, 1,   4};
    tbl[2] = '{4'd7,  8'd0,   0,   1'b0, 1,   1};
    tbl[3] = '{4'd8,  8'd2,   -1,  1'b1, 2,   3};
    tbl[4] = '{4'd9,  8'd0,   -1,  1'b1, 0,   1};
    tbl[5] = '{4'd10, 8'd1,   0,   1'b1, 0,   2};
    tbl[6] = '{4'd3,  8'd15,  15,  1'b0, 16,  16};
    tbl[7] = '{4'd15, 8'd255, 255, 1'b0, 256, 256};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero_outputs("reset");
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    chk("awready_after_reset", 64'(awready), 64'd1);

    // Basic burst with AW-to-wready latency
    n0 = n_resp;
    send_burst(4'd5, 8'd3, 3, 32'hA0);
    wait_resp(n0 + 1, 100, "basic_timeout");
    chk("aw_to_wready_latency", 64'(wready_rise_cyc - aw_fire_cyc), 64'd2);
    chk("basic_resp", 64'({last_resp_id, last_resp_err}), 64'({4'd5, 1'b0}));
    chk("basic_beats", 64'(last_tot), 64'd4);

    // Table of bursts
    for (int v = 0; v < 8; v++) begin
      n0 = n_resp;
      send_burst(tbl[v].id, tbl[v].len, tbl[v].last_at, 32'(v) << 16);
      wait_resp(n0 + 1, 600, $sformatf("tbl%0d_timeout", v));
      chk($sformatf("tbl%0d_id", v),    64'(last_resp_id),  64'(tbl[v].id));
      chk($sformatf("tbl%0d_err", v),   64'(last_resp_err), 64'(tbl[v].exp_err));
      chk($sformatf("tbl%0d_good", v),  64'(last_good),     64'(tbl[v].exp_good));
      chk($sformatf("tbl%0d_total", v), 64'(last_tot),      64'(tbl[v].exp_total));
    end

    // Missing WLAST, then a stray beat must wait for the next command
    n0 = n_resp;
    send_burst(4'd4, 8'd2, -1, 32'hC0);
    w_q.push_back('{data: 32'hDEAD_BEEF, strb: 4'h3, last: 1'b1});
    wait_resp(n0 + 1, 100, "nolast_timeout");
    chk("nolast_err", 64'(last_resp_err), 64'd1);
    repeat (10) @(posedge clk);
    chk("stray_beat_held", 64'(w_q.size()), 64'd1);
    aw_q.push_back('{id: 4'hB, len: 8'd0});
    wait_resp(n0 + 2, 100, "stray_timeout");
    chk("stray_resp", 64'({last_resp_id, last_resp_err}), 64'({4'hB, 1'b0}));
    chk("stray_good", 64'(last_good), 64'd1);

    // FIFO full while response is held off; responses in AW order
    resp_mode = 1;
    n0 = n_resp;
    for (int id = 1; id <= 5; id++) send_burst(4'(id), 8'd0, 0, 32'h100 * 32'(id));
    i = 0;
    while (aw_q.size() > 0 && i < 50) begin @(posedge clk); i++; end
    chk("five_aw_accepted", 64'(aw_q.size()), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("full_awready", 64'(awready), 64'd0);
    chk("held_resp", 64'({resp_valid, resp_id}), 64'({1'b1, 4'd1}));
    send_burst(4'd6, 8'd0, 0, 32'h600);
    repeat (10) @(posedge clk);
    chk("sixth_aw_blocked", 64'(aw_q.size()), 64'd1);
    resp_mode = 0;
    wait_resp(n0 + 6, 200, "drain_timeout");
    chk("drain_last_id", 64'(last_resp_id), 64'd6);

    // Memory back-pressure pattern 1,0,0,1
    mem_mode = 1;
    pc = 0;
    n0 = n_resp;
    send_burst(4'd7, 8'd7, 7, 32'hE0);
    wait_resp(n0 + 1, 200, "bp_timeout");
    chk("bp_total", 64'(last_tot), 64'd8);
    chk("bp_good", 64'(last_good), 64'd8);
    chk("bp_resp_after_drain", 64'(resp_rise_cyc - last_mem_cyc), 64'd1);
    mem_mode = 0;

    // Reset in the middle of a burst with commands queued
    aw_q.push_back('{id: 4'd2, len: 8'd5});
    aw_q.push_back('{id: 4'd3, len: 8'd0});
    aw_q.push_back('{id: 4'd4, len: 8'd0});
    w_q.push_back('{data: 32'h1, strb: 4'hF, last: 1'b0});
    w_q.push_back('{data: 32'h2, strb: 4'hF, last: 1'b0});
    nw0 = n_wfire;
    i = 0;
    while (n_wfire < nw0 + 2 && i < 50) begin @(posedge clk); i++; end
    chk("midburst_beats", 64'(n_wfire - nw0), 64'd2);
    n0 = n_resp;
    #2 rst = 1'b1;
    aw_q.delete();
    w_q.delete();
    @(negedge clk);
    chk("rst_awready_forced", 64'(awready), 64'd0);
    chk("busy_before_reset", 64'(busy), 64'd1);
    @(negedge clk);
    chk_zero_outputs("midrst");
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    chk("awready_after_midrst", 64'(awready), 64'd1);
    repeat (20) @(posedge clk);
    chk("no_resp_after_rst", 64'(n_resp - n0), 64'd0);

    // Randomised traffic against the reference model
    aw_rate = 70; w_rate = 70; mem_mode = 2; resp_mode = 2;
    n0 = n_resp;
    for (int k = 0; k < 40; k++) begin
      len = 8'($urandom_range(7));
      aw_q.push_back('{id: 4'($urandom_range(15)), len: len});
      for (int b = 0; b <= int'(len); b++)
        w_q.push_back('{data: $urandom, strb: 4'($urandom_range(15)),
                        last: (b == int'(len)) ^ ($urandom_range(7) == 0)});
    end
    wait_resp(n0 + 40, 20000, "random_timeout");
    repeat (5) @(posedge clk);
    chk("random_mem_left", 64'(m_mem.size()), 64'd0);
    chk("random_resp_left", 64'(m_resp.size()), 64'd0);
    chk("random_cmd_left", 64'(m_cmd.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
